// File: rtl/mux21_rr_arb_pkg.sv
// ----------------------------------------------------------------------------
// mux21_pkg
//   Shared definitions for the two-source round-robin arbiter that drives the
//   select line of mux21.
//   - state_t    : arbiter preference (ST_PREF0 = source 0 preferred,
//                  ST_PREF1 = source 1 preferred)
//   - BURST_W    : width of the burst counter
//   - other_pref : returns the opposite preference
// ----------------------------------------------------------------------------
package mux21_pkg;

    typedef enum logic {
        ST_PREF0 = 1'b0,
        ST_PREF1 = 1'b1
    } state_t;

    localparam int unsigned BURST_W = 4;

    function automatic state_t other_pref(input state_t s);
        return (s == ST_PREF0) ? ST_PREF1 : ST_PREF0;
    endfunction

endpackage

// File: rtl/mux21_rr_arb_if.sv
// ----------------------------------------------------------------------------
// mux21_rr_arb_if
//   Bundles the two valid/ready input streams, the select output and the
//   registered valid/ready output stream of mux21_rr_arb.
//   Signals:
//     in0_valid/in0_data/in0_ready : source 0 stream
//     in1_valid/in1_data/in1_ready : source 1 stream
//     sel                          : current grant, wires to mux21.s
//     out_valid/out_data/out_src   : registered winning beat and its source
//     out_ready                    : downstream accepts the beat
//   Modports:
//     slave  : arbiter view (consumes inputs, produces readies/outputs)
//     master : environment view (produces inputs, consumes readies/outputs)
// ----------------------------------------------------------------------------
interface mux21_rr_arb_if #(
    parameter int unsigned WIDTH = 8
);

    logic             in0_valid;
    logic [WIDTH-1:0] in0_data;
    logic             in0_ready;
    logic             in1_valid;
    logic [WIDTH-1:0] in1_data;
    logic             in1_ready;
    logic             sel;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_src;

    modport slave (
        input  in0_valid, in0_data, in1_valid, in1_data, out_ready,
        output in0_ready, in1_ready, sel, out_valid, out_data, out_src
    );

    modport master (
        output in0_valid, in0_data, in1_valid, in1_data, out_ready,
        input  in0_ready, in1_ready, sel, out_valid, out_data, out_src
    );

endinterface

// File: rtl/mux21.sv
// ----------------------------------------------------------------------------
// mux21
//   Single-bit 2:1 multiplexer.
//   Ports: d0 (selected when s=0), d1 (selected when s=1), s (select), y.
// ----------------------------------------------------------------------------
module mux21 (
    input  logic d0,
    input  logic d1,
    input  logic s,
    output logic y
);

    assign y = s ? d1 : d0;

endmodule

// File: rtl/mux21_rr_arb_out_reg.sv
// ----------------------------------------------------------------------------
// mux21_out_reg
//   One-entry valid/ready output register holding a data word and the index
//   of the source it came from.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     i_accept   : load i_data/i_src this edge
//     i_data     : payload to capture
//     i_src      : source index to capture
//     i_ready    : downstream accepts the held beat
//     o_valid    : register holds a beat
//     o_data     : held payload
//     o_src      : held source index
// ----------------------------------------------------------------------------
module mux21_out_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_accept,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_src,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_src
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic             r_src;

    // A new beat has priority over draining: with both in one edge the old
    // beat leaves and the new one lands without a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_src   <= 1'b0;
        end else if (i_accept) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_src   <= i_src;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_src   = r_src;

endmodule

// File: rtl/mux21_rr_arb.sv
// ----------------------------------------------------------------------------
// mux21_rr_arb
//   Two-source round-robin arbiter placed upstream of mux21. Each cycle it
//   picks one of two valid/ready streams, exports the choice on sel (to
//   mux21.s) and captures the winning beat in a one-entry output register.
//   A burst counter limits how many consecutive beats the preferred source
//   may win while the other source is waiting.
//   Parameters:
//     WIDTH     : payload width
//     MAX_BURST : beats granted to one source under contention (1..15)
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     bus        : mux21_rr_arb_if slave modport (streams, sel, output beat)
// ----------------------------------------------------------------------------
module mux21_rr_arb
    import mux21_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    mux21_rr_arb_if.slave   bus
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [BURST_W-1:0] r_burst_cnt;
    logic [BURST_W-1:0] w_burst_nxt;
    logic [BURST_W-1:0] w_burst_inc;

    logic             w_grant;
    logic             w_load;
    logic             w_accept;
    logic             w_other_valid;
    logic [WIDTH-1:0] w_mux_data;
    logic             w_out_valid;
    logic [WIDTH-1:0] w_out_data;
    logic             w_out_src;

    // Grant: a lone requester always wins; on contention or idle the
    // preferred index is used. sel parks at 0 while reset is held.
    always_comb begin
        w_grant = (r_state == ST_PREF1);
        if (bus.in0_valid && !bus.in1_valid) begin
            w_grant = 1'b0;
        end else if (bus.in1_valid && !bus.in0_valid) begin
            w_grant = 1'b1;
        end
        if (!rst_n) begin
            w_grant = 1'b0;
        end
    end

    assign w_load        = !w_out_valid || bus.out_ready;
    assign w_accept      = rst_n && w_load && (w_grant ? bus.in1_valid : bus.in0_valid);
    assign w_other_valid = w_grant ? bus.in0_valid : bus.in1_valid;

    assign bus.sel       = w_grant;
    assign bus.in0_ready = w_accept && !w_grant;
    assign bus.in1_ready = w_accept &&  w_grant;

    // Burst accounting. Under contention the winner is always the preferred
    // source, so counting accepts-with-rival is counting the preferred
    // source's streak.
    assign w_burst_inc = r_burst_cnt + BURST_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_burst_nxt = r_burst_cnt;
        if (w_accept) begin
            if (w_other_valid) begin
                if (w_burst_inc == BURST_W'(MAX_BURST)) begin
                    w_state_nxt = other_pref(r_state);
                    w_burst_nxt = '0;
                end else begin
                    w_burst_nxt = w_burst_inc;
                end
            end else begin
                w_burst_nxt = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_PREF0;
            r_burst_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_burst_cnt <= w_burst_nxt;
        end
    end

    // Data path: one mux21 per payload bit, all steered by the grant.
    for (genvar gi = 0; gi < int'(WIDTH); gi++) begin : g_mux
        mux21 u_mux21 (
            .d0 (bus.in0_data[gi]),
            .d1 (bus.in1_data[gi]),
            .s  (w_grant),
            .y  (w_mux_data[gi])
        );
    end

    mux21_out_reg #(
        .WIDTH (WIDTH)
    ) u_out_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_accept (w_accept),
        .i_data   (w_mux_data),
        .i_src    (w_grant),
        .i_ready  (bus.out_ready),
        .o_valid  (w_out_valid),
        .o_data   (w_out_data),
        .o_src    (w_out_src)
    );

    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = w_out_data;
    assign bus.out_src   = w_out_src;

endmodule

// File: tb/tb_mux21_rr_arb.sv
// ----------------------------------------------------------------------------
// tb_mux21_rr_arb
//   Self-checking bench for mux21_rr_arb: directed scenarios with literal
//   expectations followed by randomized valid/ready traffic, all compared
//   every cycle against a behavioural model of the arbitration rules.
// ----------------------------------------------------------------------------
module tb_mux21_rr_arb;

    localparam int unsigned WIDTH     = 8;
    localparam int unsigned MAX_BURST = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    mux21_rr_arb_if #(.WIDTH(WIDTH)) bus ();

    mux21_rr_arb #(
        .WIDTH     (WIDTH),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_pref   : which source wins a tie
    // m_streak : consecutive beats won by the preferred source while the
    //            other one was waiting
    // m_full/m_data/m_src : the beat expected in the output register
    int         m_pref = 0, m_streak = 0, m_src = 0;
    bit         m_full = 1'b0;
    logic [7:0] m_data = '0;
    int         p_pref = 0, p_streak = 0, p_src = 0;
    bit         p_full = 1'b0;
    logic [7:0] p_data = '0;
    int         mw;
    bit         mtake, mrival;

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_sel",       bus.sel,       0);
            check("rst_in0_ready", bus.in0_ready, 0);
            check("rst_in1_ready", bus.in1_ready, 0);
            check("rst_out_valid", bus.out_valid, 0);
            check("rst_out_data",  bus.out_data,  0);
            p_pref = 0; p_streak = 0; p_full = 1'b0; p_data = '0; p_src = 0;
        end else begin
            if (bus.in0_valid && bus.in1_valid) mw = m_pref;
            else if (bus.in0_valid)             mw = 0;
            else if (bus.in1_valid)             mw = 1;
            else                                mw = m_pref;
            mtake  = (bus.in0_valid || bus.in1_valid) && (!m_full || bus.out_ready);
            mrival = (mw == 0) ? bus.in1_valid : bus.in0_valid;

            check("sel",       bus.sel,       mw);
            check("in0_ready", bus.in0_ready, mtake && mw == 0);
            check("in1_ready", bus.in1_ready, mtake && mw == 1);
            check("out_valid", bus.out_valid, m_full);
            if (m_full) begin
                check("out_data", bus.out_data, m_data);
                check("out_src",  bus.out_src,  m_src);
            end

            p_pref = m_pref; p_streak = m_streak; p_full = m_full;
            p_data = m_data; p_src = m_src;
            if (mtake) begin
                p_full = 1'b1;
                p_data = (mw == 1) ? bus.in1_data : bus.in0_data;
                p_src  = mw;
                if (mrival) begin
                    p_streak = m_streak + 1;
                    if (p_streak >= int'(MAX_BURST)) begin
                        p_pref   = 1 - m_pref;
                        p_streak = 0;
                    end
                end else begin
                    p_streak = 0;
                end
            end else if (m_full && bus.out_ready) begin
                p_full = 1'b0;
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pref = 0; m_streak = 0; m_full = 1'b0; m_data = '0; m_src = 0;
        end else begin
            m_pref = p_pref; m_streak = p_streak; m_full = p_full;
            m_data = p_data; m_src = p_src;
        end
    end

    // ---------------- stimulus helpers ----------------
    int a = 0, b = 0;

    task automatic drive(input logic v0, input logic [7:0] d0,
                         input logic v1, input logic [7:0] d1, input logic ordy);
        bus.in0_valid = v0;
        bus.in0_data  = d0;
        bus.in1_valid = v1;
        bus.in1_data  = d1;
        bus.out_ready = ordy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Both sources valid every beat; pat[k] is the source expected to win beat k.
    task automatic run_beats(input string name, input int n, input logic [15:0] pat);
        for (int k = 0; k < n; k++) begin
            drive(1'b1, 8'(8'hA0 + a), 1'b1, 8'(8'hB0 + b), 1'b1);
            @(negedge clk);
            check({name, "_sel"}, bus.sel, pat[k]);
            step();
            check({name, "_src"},  bus.out_src,  pat[k]);
            check({name, "_data"}, bus.out_data, pat[k] ? 8'(8'hB0 + b) : 8'(8'hA0 + a));
            if (pat[k]) b++; else a++;
        end
    endtask

    // Only one source valid for n beats.
    task automatic solo(input string name, input logic src, input int n);
        for (int k = 0; k < n; k++) begin
            if (src) drive(1'b0, 8'h00, 1'b1, 8'(8'hB0 + b), 1'b1);
            else     drive(1'b1, 8'(8'hA0 + a), 1'b0, 8'h00, 1'b1);
            step();
            check({name, "_src"},  bus.out_src,  src);
            check({name, "_data"}, bus.out_data, src ? 8'(8'hB0 + b) : 8'(8'hA0 + a));
            if (src) b++; else a++;
        end
    endtask

    logic [7:0] single_d [3] = '{8'h11, 8'h22, 8'h33};
    logic       acc0, acc1;

    initial begin
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

        // Reset held with random inputs: nothing may be granted or loaded.
        for (int k = 0; k < 4; k++) begin
            drive(1'($urandom), 8'($urandom), 1'($urandom), 8'($urandom), 1'($urandom));
            @(negedge clk);
            check("reset_in0_ready", bus.in0_ready, 0);
            check("reset_in1_ready", bus.in1_ready, 0);
            check("reset_sel",       bus.sel,       0);
            check("reset_out_valid", bus.out_valid, 0);
            check("reset_out_data",  bus.out_data,  0);
        end
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        check("post_reset_out_valid", bus.out_valid, 0);
        check("post_reset_out_data",  bus.out_data,  0);
        check("post_reset_sel",       bus.sel,       0);

        // Single source, one beat per cycle.
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, single_d[k], 1'b0, 8'h00, 1'b1);
            step();
            check("single_data", bus.out_data, single_d[k]);
            check("single_src",  bus.out_src,  0);
            check("single_sel",  bus.sel,      0);
        end
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        step();
        step();

        // Contention with MAX_BURST=4: 0,0,0,0,1,1,1,1,0,0
        run_beats("contend", 10, 16'h00F0);

        // Backpressure: held beat A5, preference 0 with streak 2.
        drive(1'b1, 8'(8'hA0 + a), 1'b1, 8'(8'hB0 + b), 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_in0_ready", bus.in0_ready, 0);
            check("stall_in1_ready", bus.in1_ready, 0);
            check("stall_sel",       bus.sel,       0);
            check("stall_out_data",  bus.out_data,  8'hA5);
            check("stall_out_valid", bus.out_valid, 1);
            @(posedge clk);
            #1;
        end
        // Streak resumes at 2: two more from source 0, then source 1.
        run_beats("resume", 4, 16'h000C);

        // Preference is now 1. Lone requesters clear the streak without
        // moving the preference, so contention then gives source 1 a full burst.
        solo("idle0", 1'b0, 2);
        solo("idle1", 1'b1, 2);
        run_beats("idle_pref", 5, 16'h000F);
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        step();
        step();

        // Async reset between edges while a beat is held.
        drive(1'b1, 8'(8'hA0 + a), 1'b1, 8'(8'hB0 + b), 1'b0);
        step();
        check("pre_async_out_valid", bus.out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_out_valid", bus.out_valid, 0);
        check("async_out_data",  bus.out_data,  0);
        check("async_in0_ready", bus.in0_ready, 0);
        check("async_in1_ready", bus.in1_ready, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        check("async_first_sel",   bus.sel,       0);
        check("async_first_ready", bus.in0_ready, 1);
        step();
        check("async_first_src",  bus.out_src,  0);
        check("async_first_data", bus.out_data, 8'(8'hA0 + a));
        a++;
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        step();
        step();

        // Randomized traffic honouring the hold-until-accepted rule.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            acc0 = bus.in0_ready;
            acc1 = bus.in1_ready;
            @(posedge clk);
            #1;
            if (!bus.in0_valid || acc0) begin
                bus.in0_valid = ($urandom_range(3) != 0);
                bus.in0_data  = 8'($urandom);
            end
            if (!bus.in1_valid || acc1) begin
                bus.in1_valid = ($urandom_range(2) != 0);
                bus.in1_data  = 8'($urandom);
            end
            bus.out_ready = ($urandom_range(3) != 0);
        end
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        step();
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "time limit");
    end

endmodule

// File: doc/mux21_rr_arb.md
Name: mux21_rr_arb

Overview:
- Two-source round-robin arbiter that sits directly upstream of mux21 and drives its select line s.
- Takes two valid/ready data streams and chooses one per beat.
- Exports the chosen index on `sel`, which wires to mux21.s.
- Also provides a registered, handshaked copy of the winning data for downstream logic.
- A burst counter bounds how long one source may hold the grant while the other is waiting.

Parameters:
- WIDTH, 8, data width of each input and of out_data.
- MAX_BURST, 4, max consecutive beats granted to one source while the other is requesting (legal range 1..15).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in0_valid  input  1  source 0 has data.
- in0_data  input  WIDTH  source 0 payload.
- in0_ready  output  1  source 0 beat accepted this cycle.
- in1_valid  input  1  source 1 has data.
- in1_data  input  WIDTH  source 1 payload.
- in1_ready  output  1  source 1 beat accepted this cycle.
- sel  output  1  current grant (0 = in0, 1 = in1), connects to mux21.s.
- out_valid  output  1  out_data holds a beat.
- out_ready  input  1  downstream accepts the beat.
- out_data  output  WIDTH  registered winning payload.
- out_src  output  1  source index of the beat held in out_data.

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=0, out_data=0, out_src=0, burst_cnt=0, state=PREF0.
  - Reset mid-transfer discards the held beat; no handshake fires while rst_n is low.
- Load enable: load = !out_valid || out_ready. This is a one-entry pipeline register; full throughput at out_ready=1.
- States:
  - PREF0: source 0 has priority.
  - PREF1: source 1 has priority.
- Grant (combinational, from state and valids):
  - Only one source valid: grant that source.
  - Both valid: grant the preferred source.
  - Neither valid: grant holds the preferred index.
- Outputs derived from grant:
  - sel = grant, every cycle, including while stalled, so the mux sees a stable select.
  - in0_ready = load && in0_valid && grant==0.
  - in1_ready = load && in1_valid && grant==1.
  - At most one ready is high per cycle.
- Accepted beat: on an edge where a ready was high:
  - out_data <= selected data.
  - out_src <= grant.
  - out_valid <= 1.
- Drain: on an edge with out_valid && out_ready and no accept, out_valid <= 0.
- Latency: a beat accepted at edge N appears on out_data after edge N; 1 cycle.
- Burst counter (4 bits):
  - On an accept while the other source is also valid: increment burst_cnt.
  - When the increment reaches MAX_BURST: switch preference to the other source and clear burst_cnt.
  - On an accept with the other source idle: clear burst_cnt, keep preference.
  - Other source granted: preference stays with it and burst_cnt restarts from 0.
- Stall: with out_valid=1 and out_ready=0:
  - No accept; state and burst_cnt frozen.
  - out_data stable.
  - Inputs must hold valid/data (standard valid/ready rule).
- Simultaneous drain+accept (out_ready=1, out_valid=1, input valid): new beat replaces the old in the same edge, with no bubble.
- MAX_BURST=1: strict alternation whenever both sources are valid.

Decomposition:
- Shared package `mux21_pkg`: state encoding localparams ST_PREF0=1'b0, ST_PREF1=1'b1; counter width constant BURST_W=4.
- One natural sub-module: `mux21_out_reg`, the one-entry valid/ready output register holding data+src.
- Arbiter FSM and counter stay in the top module.
- Top instantiates mux21 for the data path, with d0=in0_data bit, d1=in1_data bit, s=sel, per bit of WIDTH via generate.

Test Plan:
- Reset: hold rst_n=0 with random inputs, then release -> out_valid=0, out_data=0, sel=0, both readies 0 during reset.
- Single source: in0_valid=1 with data 0x11,0x22,0x33, out_ready=1 -> out_data shows 0x11,0x22,0x33 on consecutive cycles, out_src=0, sel=0.
- Contention, MAX_BURST=4: both sources valid continuously (in0 0xA0.., in1 0xB0..), out_ready=1 -> out_src pattern 0,0,0,0,1,1,1,1,0...
- Backpressure: out_ready=0 for 5 cycles mid-stream -> out_data and sel constant, both readies 0, no beat lost or duplicated after out_ready returns to 1.
- Idle preference: in1 sends 2 beats while in0 is idle -> burst_cnt stays 0; when in0 raises valid together with in1, grant follows the current preference.
- Async reset mid-burst: assert rst_n low between edges while out_valid=1 -> out_valid drops immediately; after release the first grant goes to in0.
